// File: rtl/ahb_slave_arbiter_gen.sv
// AHB slave-side burst arbiter: registered one-hot grant held for the whole burst, fixed priority by default.
// Define AHB_ARB_ROUND_ROBIN_EN to select round-robin arbitration starting after the last granted master.
module ahb_slave_arbiter_gen #(
   parameter int MASTER_NUM = 4,
   parameter int MID_W      = $clog2(MASTER_NUM)
) (
   input  logic                       hclk,
   input  logic                       hreset_n,
   input  logic [MASTER_NUM-1:0]      hreq,
   input  logic [MASTER_NUM-1:0][2:0] hburst,
   input  logic                       hwait,
   output logic [MASTER_NUM-1:0]      hgrant,
   output logic                       hsel,
   output logic [MID_W-1:0]           hmaster,
   output logic                       hlast
);

   localparam logic [2:0] BURST_SINGLE = 3'd0;
   localparam logic [2:0] BURST_INCR   = 3'd1;

   typedef enum logic {
      IDLE,
      BURST
   } stateT;

   stateT                 r_state;
   stateT                 w_nextState;
   logic [MASTER_NUM-1:0] r_grant;
   logic [MID_W-1:0]      r_master;
   logic [2:0]            r_burst;
   logic [3:0]            r_count;
   logic [3:0]            w_limit;
   logic                  w_anyReq;
   logic                  w_lastDone;
   logic                  w_newGrant;
   logic                  w_goIdle;
   logic [MID_W-1:0]      w_lowWinner;
   logic [MID_W-1:0]      w_winner;
   logic [MASTER_NUM-1:0] w_oneHot;

   assign w_anyReq   = |hreq;
   assign hgrant     = r_grant;
   assign hsel       = |r_grant;
   assign hmaster    = r_master;
   assign w_lastDone = hlast & ~hwait;

   // Final-beat index for each fixed-length burst type; INCR ends on request drop instead.
   always_comb begin
      w_limit = 4'd15;
      case (r_burst)
         3'd0:       w_limit = 4'd0;
         3'd2, 3'd3: w_limit = 4'd3;
         3'd4, 3'd5: w_limit = 4'd7;
         default:    w_limit = 4'd15;
      endcase
   end

   always_comb begin
      hlast = 1'b0;
      if (r_state == BURST) begin
         if (r_burst == BURST_INCR) hlast = ~hreq[r_master];
         else                       hlast = (r_count == w_limit);
      end
   end

   always_comb begin
      w_lowWinner = '0;
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
         if (hreq[i]) w_lowWinner = MID_W'(i);
      end
   end

`ifdef AHB_ARB_ROUND_ROBIN_EN
   logic [MID_W-1:0] r_ptr;
   logic [MID_W-1:0] w_highWinner;
   logic             w_highFound;

   // Prefer the lowest requester above the pointer; otherwise wrap to the lowest overall.
   always_comb begin
      w_highWinner = '0;
      w_highFound  = 1'b0;
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
         if (hreq[i] && (MID_W'(i) > r_ptr)) begin
            w_highWinner = MID_W'(i);
            w_highFound  = 1'b1;
         end
      end
      w_winner = w_highFound ? w_highWinner : w_lowWinner;
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n)       r_ptr <= MID_W'(MASTER_NUM - 1);
      else if (w_newGrant) r_ptr <= w_winner;
   end
`else
   assign w_winner = w_lowWinner;
`endif

   always_comb begin
      w_oneHot           = '0;
      w_oneHot[w_winner] = 1'b1;
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) r_state <= IDLE;
      else           r_state <= w_nextState;
   end

   // Arbitration happens only from IDLE or on the completing final beat.
   always_comb begin
      w_nextState = r_state;
      w_newGrant  = 1'b0;
      w_goIdle    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_nextState = BURST;
               w_newGrant  = 1'b1;
            end
         end
         BURST: begin
            if (w_lastDone) begin
               if (w_anyReq) begin
                  w_newGrant = 1'b1;
               end else begin
                  w_nextState = IDLE;
                  w_goIdle    = 1'b1;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_grant  <= '0;
         r_master <= '0;
         r_burst  <= BURST_SINGLE;
         r_count  <= '0;
      end else if (w_newGrant) begin
         r_grant  <= w_oneHot;
         r_master <= w_winner;
         r_burst  <= hburst[w_winner];
         r_count  <= '0;
      end else if (w_goIdle) begin
         r_grant  <= '0;
         r_master <= '0;
         r_burst  <= BURST_SINGLE;
         r_count  <= '0;
      end else if (hsel && !hwait && (r_count != 4'hF)) begin
         r_count  <= r_count + 4'd1;
      end
   end

endmodule
